// File: rtl/accum_drain_ctrl.sv
// -----------------------------------------------------------------------------
// accum_drain_ctrl
//
// Read-side (drain) controller for the FP16 accumulator memory. A start
// command launches a burst of sequential reads from base_addr. The
// accumulator has a one-cycle registered read latency, so each returning
// word lands in a small 2-entry output FIFO one cycle after its read was
// issued. Words leave on a valid/ready stream, optionally clamped by ReLU.
//
// Reads are throttled by a credit rule. Words already buffered plus the one
// read in flight, minus any word leaving this cycle, must stay below the FIFO
// depth. As a result a returning word always finds a free slot, even when
// out_ready is low.
//
// Ports
//   clk          clock, all state on rising edge
//   reset        asynchronous, active-high reset
//   start        command strobe, honoured only while busy=0
//   base_addr    first accumulator address of the burst
//   count        words to drain, 0..ACCUM_SIZE
//   relu_en      clamp negative words to zero for this burst
//   busy         command in progress (ISSUE/DRAIN)
//   done         one-cycle pulse at burst completion
//   acc_rd_en    accumulator read enable
//   acc_rd_addr  accumulator read address (holds last value when idle)
//   acc_rd_data  accumulator read data, valid the cycle after acc_rd_en
//   out_valid    out_data valid
//   out_ready    downstream accept
//   out_data     FP16 result
//   out_last     final word of the burst
// -----------------------------------------------------------------------------
module accum_drain_ctrl #(
   parameter  int ACCUM_SIZE = 1024,
   // Output buffer depth. Only 2 is supported: the FIFO uses 1-bit pointers.
   parameter  int FIFO_DEPTH = 2,
   localparam int AW         = $clog2(ACCUM_SIZE)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   count,
   input  logic          relu_en,
   output logic          busy,
   output logic          done,
   output logic          acc_rd_en,
   output logic [AW-1:0] acc_rd_addr,
   input  logic [15:0]   acc_rd_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [15:0]   out_data,
   output logic          out_last
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // One buffered output word together with its end-of-burst marker.
   typedef struct packed {
      logic        last;
      logic [15:0] data;
   } entry_t;

   state_t        state_q, state_d;

   // Latched command and burst progress.
   logic [AW-1:0] addr_q;        // next address to read
   logic [AW:0]   rem_q;         // reads still to issue
   logic          relu_q;
   logic [AW-1:0] last_addr_q;   // last issued address, shown while idle

   // Read in flight: issued last cycle, data is on acc_rd_data now.
   logic          inflight_q;
   logic          inflight_last_q;

   // 2-entry output FIFO.
   entry_t        fifo_mem [2];
   logic          wr_ptr_q, rd_ptr_q;
   logic [1:0]    fifo_cnt_q;

   logic          cmd_accept;
   logic          issue;
   logic          credit;
   logic          push;
   logic          pop;
   logic [2:0]    occupancy;
   logic [2:0]    capacity;
   logic [AW-1:0] addr_inc;
   entry_t        push_entry;
   entry_t        head;

   // -------------------------------------------------------------------------
   // Handshake and credit
   // -------------------------------------------------------------------------
   // A start is honoured in IDLE and also in the DONE cycle, so bursts can
   // run back to back without an extra idle cycle.
   assign cmd_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   assign out_valid  = (fifo_cnt_q != 2'd0);
   assign pop        = out_valid && out_ready;
   assign push       = inflight_q;

   // The comparison occupancy - pop < depth is rewritten as
   // occupancy < depth + pop. This keeps the arithmetic unsigned.
   // The pop term makes issue depend combinationally on out_ready. That lets
   // a full FIFO that is being drained keep issuing without a bubble.
   assign occupancy  = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
   assign capacity   = 3'(FIFO_DEPTH) + {2'b00, pop};
   assign credit     = (occupancy < capacity);

   // ISSUE is only ever entered with rem_q > 0, so credit is the only gate.
   assign issue      = (state_q == S_ISSUE) && credit;

   // Explicit wrap, so a non-power-of-two depth also wraps correctly.
   assign addr_inc   = (addr_q == AW'(ACCUM_SIZE - 1)) ? '0 : addr_q + 1'b1;

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // -------------------------------------------------------------------------
   // FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (cmd_accept)
               state_d = (count == '0) ? S_DONE : S_ISSUE;
            else
               state_d = S_IDLE;
         end
         S_ISSUE: begin
            if (issue && (rem_q == (AW+1)'(1)))
               state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // The last word cannot leave before the FSM reaches DRAIN.
            // It is issued in ISSUE and needs at least two more edges to
            // reach the FIFO head.
            if (pop && head.last)
               state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs
   // -------------------------------------------------------------------------
   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      acc_rd_en   = 1'b0;
      acc_rd_addr = last_addr_q;
      case (state_q)
         S_ISSUE: begin
            busy = 1'b1;
            if (issue) begin
               acc_rd_en   = 1'b1;
               acc_rd_addr = addr_q;
            end
         end
         S_DRAIN: busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Command latch and address/count progress
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q      <= '0;
         rem_q       <= '0;
         relu_q      <= 1'b0;
         last_addr_q <= '0;
      end else if (cmd_accept) begin
         addr_q <= base_addr;
         rem_q  <= count;
         relu_q <= relu_en;
      end else if (issue) begin
         addr_q      <= addr_inc;
         rem_q       <= rem_q - 1'b1;
         last_addr_q <= addr_q;
      end
   end

   // -------------------------------------------------------------------------
   // Read-latency tracking
   // -------------------------------------------------------------------------
   // The end-of-burst marker travels with the read so the FIFO entry can
   // carry it. No separate output-side counter is needed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         inflight_q      <= issue;
         inflight_last_q <= issue && (rem_q == (AW+1)'(1));
      end
   end

   // -------------------------------------------------------------------------
   // Output FIFO
   // -------------------------------------------------------------------------
   // Sign bit set means negative, -0, or negative NaN/Inf. All of these
   // clamp to +0.
   always_comb begin
      push_entry.last = inflight_last_q;
      push_entry.data = (relu_q && acc_rd_data[15]) ? 16'h0000 : acc_rd_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         fifo_cnt_q  <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr_q] <= push_entry;
            wr_ptr_q           <= ~wr_ptr_q;
         end
         if (pop)
            rd_ptr_q <= ~rd_ptr_q;
         fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head = fifo_mem[rd_ptr_q];

   // Gate with out_valid so no stale entry ever shows up on the bus.
   assign out_data = out_valid ? head.data : 16'h0000;
   assign out_last = out_valid && head.last;

endmodule

// File: tb/tb_accum_drain_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for accum_drain_ctrl.
//
// The bench models the accumulator as an array with a one-cycle registered
// read. Commands push the words the burst should produce, computed directly
// from memory contents and the ReLU rule, into a scoreboard queue. They also
// push the addresses the burst should read. Monitor processes on the falling
// edge check reads, output handshakes, the done pulse, stall stability, and
// the outstanding-read bound.
// -----------------------------------------------------------------------------
module tb_accum_drain_ctrl;

   localparam int ACCUM_SIZE = 1024;
   localparam int AW         = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   count = '0;
   logic          relu_en = 1'b0;
   logic          busy, done, acc_rd_en, out_valid, out_last;
   logic [AW-1:0] acc_rd_addr;
   logic [15:0]   acc_rd_data = 16'h0;
   logic [15:0]   out_data;
   logic          out_ready = 1'b0;

   always #5 clk = ~clk;

   accum_drain_ctrl #(.ACCUM_SIZE(ACCUM_SIZE), .FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .count(count), .relu_en(relu_en), .busy(busy), .done(done),
      .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr),
      .acc_rd_data(acc_rd_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last)
   );

   typedef struct {
      logic [15:0] data;
      logic        last;
   } word_t;

   logic [15:0] mem [ACCUM_SIZE];
   word_t       exp_q[$];
   int          addr_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        done_due = 1'b0;
   int          ready_mode = 0;     // 0: always ready, 1: random, 2: 1,0,0 pattern
   int          rd_issued = 0;
   int          wd_accepted = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endfunction

   function automatic void fail(string name);
      checks++;
      errors++;
      $display("FAIL %s t=%0t", name, $time);
   endfunction

   // ---------------- accumulator memory model (registered read) -------------
   logic          rd_en_s = 1'b0;
   logic [AW-1:0] rd_addr_s = '0;
   always @(negedge clk) begin
      rd_en_s   = acc_rd_en;
      rd_addr_s = acc_rd_addr;
   end
   // Random data when no read is pending: the DUT must ignore it.
   always @(posedge clk)
      acc_rd_data <= rd_en_s ? mem[rd_addr_s] : 16'($urandom);

   // ---------------- downstream ready driver --------------------------------
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: begin out_ready = (ph % 3 == 0); ph++; end
         endcase
      end
   end

   // ---------------- monitor / scoreboard -----------------------------------
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = '0;
   logic        prev_last = 1'b0;

   always @(negedge clk) begin
      word_t w;
      if (reset) begin
         prev_stall  = 1'b0;
         rd_issued   = 0;
         wd_accepted = 0;
      end else begin
         if (done || done_due) chk("done_pulse", done, done_due);
         done_due = 1'b0;

         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
            chk("stall_last", out_last, prev_last);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;

         if (acc_rd_en) begin
            rd_issued++;
            if (addr_q.size() == 0) fail("unexpected_read");
            else chk("rd_addr", acc_rd_addr, addr_q.pop_front());
         end
         if (out_valid && out_ready) begin
            wd_accepted++;
            if (exp_q.size() == 0) fail("unexpected_word");
            else begin
               w = exp_q.pop_front();
               chk("out_data", out_data, w.data);
               chk("out_last", out_last, w.last);
               if (w.last) done_due = 1'b1;
            end
         end
         if (acc_rd_en) chk("outstanding_gt2", 32'(rd_issued - wd_accepted > 2), 0);
      end
   end

   // ---------------- driver helpers -----------------------------------------
   task automatic push_exp(int b, int n, bit r);
      int    a;
      word_t w;
      for (int i = 0; i < n; i++) begin
         a = (b + i) % ACCUM_SIZE;
         addr_q.push_back(a);
         w.data = (r && mem[a][15]) ? 16'h0000 : mem[a];
         w.last = (i == n - 1);
         exp_q.push_back(w);
      end
   endtask

   // Call between edges; returns at posedge+1 after the accepting edge.
   task automatic issue_cmd(int b, int n, bit r);
      base_addr = AW'(b);
      count     = 11'(n);
      relu_en   = r;
      start     = 1'b1;
      push_exp(b, n, r);
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 0) done_due = 1'b1;
      chk("busy_after_start", busy, (n > 0));
   endtask

   // Returns at the falling edge of the done cycle.
   task automatic wait_done(int exp_lat, bit chk_lat);
      int cyc;
      bit seen;
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         seen = done;
      end
      if (!seen) fail("done_timeout");
      else begin
         if (chk_lat) chk("latency", cyc, exp_lat);
         chk("busy_in_done", busy, 0);
         chk("scoreboard_empty", exp_q.size(), 0);
      end
   endtask

   task automatic next_slot();
      @(posedge clk); #1;
   endtask

   task automatic check_zero_outputs(string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rd_en"}, acc_rd_en, 0);
      chk({tag, "_rd_addr"}, acc_rd_addr, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_last"}, out_last, 0);
   endtask

   // ---------------- main sequence ------------------------------------------
   initial begin
      int b, n, m, w0, cyc;
      bit r;
      for (int i = 0; i < ACCUM_SIZE; i++) mem[i] = 16'($urandom);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero_outputs("reset");
      next_slot();
      reset = 1'b0;
      next_slot();

      // Basic burst.
      ready_mode = 0;
      mem[16] = 16'h3C00; mem[17] = 16'h4000; mem[18] = 16'hC000; mem[19] = 16'h0000;
      issue_cmd(16, 4, 0);
      wait_done(7, 1);
      next_slot();

      // ReLU, including -0 and negative NaN.
      mem[20] = 16'h8000; mem[21] = 16'hFE00;
      issue_cmd(16, 6, 1);
      wait_done(9, 1);
      next_slot();

      // Address wrap.
      issue_cmd(1022, 4, 0);
      wait_done(7, 1);
      next_slot();

      // Backpressure, ready pattern 1,0,0.
      ready_mode = 2;
      issue_cmd(40, 8, 0);
      wait_done(0, 0);
      next_slot();

      // Zero-length command.
      ready_mode = 0;
      issue_cmd(5, 0, 0);
      wait_done(1, 1);
      next_slot();

      // Start while busy is ignored.
      ready_mode = 1;
      issue_cmd(100, 10, 0);
      repeat (2) next_slot();
      base_addr = 10'd500; count = 11'd3; start = 1'b1;
      next_slot();
      start = 1'b0;
      wait_done(0, 0);
      next_slot();

      // Start in the done cycle launches the next burst.
      ready_mode = 0;
      issue_cmd(200, 5, 1);
      wait_done(8, 1);
      issue_cmd(300, 3, 0);
      wait_done(6, 1);
      next_slot();

      // Randomised bursts.
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < ACCUM_SIZE; i++) mem[i] = 16'($urandom);
         b = $urandom_range(0, ACCUM_SIZE - 1);
         n = $urandom_range(1, 40);
         r = 1'($urandom);
         m = $urandom_range(0, 2);
         ready_mode = m;
         issue_cmd(b, n, r);
         wait_done(n + 3, (m == 0));
         next_slot();
      end

      // Full-depth burst.
      ready_mode = 0;
      b = $urandom_range(0, ACCUM_SIZE - 1);
      issue_cmd(b, ACCUM_SIZE, 1);
      wait_done(ACCUM_SIZE + 3, 1);
      next_slot();

      // Reset mid-burst after 3 accepted words.
      w0 = wd_accepted;
      issue_cmd(50, 8, 0);
      cyc = 0;
      while (wd_accepted - w0 < 3 && cyc < 100) begin
         @(negedge clk); #1;
         cyc++;
      end
      if (wd_accepted - w0 < 3) fail("midburst_timeout");
      #2 reset = 1'b1;
      #1 check_zero_outputs("midreset");
      exp_q.delete();
      addr_q.delete();
      done_due = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      next_slot();
      for (int i = 0; i < ACCUM_SIZE; i++) mem[i] = 16'($urandom);
      issue_cmd(50, 8, 0);
      wait_done(11, 1);
      next_slot();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/accum_drain_ctrl.md
Name: accum_drain_ctrl

Overview:
Read-side controller for the FP16 accumulator memory. On a start command it issues a burst of sequential reads from a base address and absorbs the accumulator's one-cycle registered read latency. Results are streamed out on a valid/ready interface toward the output/unified buffer, with optional ReLU applied. It is the drain end of the accumulator; the systolic array remains the write/accumulate end.

Parameters:
ACCUM_SIZE, 1024, accumulator depth in FP16 words; address width AW = $clog2(ACCUM_SIZE)
FIFO_DEPTH, 2, output buffer entries; fixed at 2, other values not supported

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  command strobe, sampled only when busy=0
base_addr  input  AW  first accumulator address of the burst
count  input  AW+1  number of words to drain, 0..ACCUM_SIZE
relu_en  input  1  apply ReLU to this burst; latched with start
busy  output  1  command in progress
done  output  1  one-cycle pulse at burst completion
acc_rd_en  output  1  accumulator read enable
acc_rd_addr  output  AW  accumulator read address
acc_rd_data  input  16  accumulator read data, valid the cycle after acc_rd_en
out_valid  output  1  out_data valid
out_ready  input  1  downstream accept
out_data  output  16  FP16 result
out_last  output  1  marks the final word of the burst

Behaviour:
- Reset (async, any time including mid-burst): state=IDLE, busy=0, done=0, acc_rd_en=0, acc_rd_addr=0, out_valid=0, out_data=0, out_last=0. FIFO flushed, in-flight flag cleared, latched command cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start=1, latch base_addr, count and relu_en. Go to ISSUE if count>0. Go to DONE if count==0; no reads are issued and no words are output.
- ISSUE: assert acc_rd_en with acc_rd_addr = current address when credit is available.
  - Credit: fifo_count + inflight - (out_valid & out_ready) < 2.
  - acc_rd_en may depend combinationally on out_ready.
  - After each issued read: address increments modulo ACCUM_SIZE, wrapping from ACCUM_SIZE-1 to 0. Remaining count decrements.
  - Go to DRAIN after the last read issues.
  - acc_rd_addr holds its last value when acc_rd_en=0.
- In-flight: a read issued in cycle N sets inflight. acc_rd_data is written into the FIFO at the end of cycle N+1, regardless of out_ready; credit guarantees space.
  - acc_rd_data is ignored in any cycle with no read in flight.
- ReLU: when latched relu_en=1 and data[15]=1, store 16'h0000. This covers -0 and negative NaN/Inf. Otherwise data passes unchanged.
- Output: out_valid = FIFO not empty. out_data and out_last come from the FIFO head and are stable while out_valid=1 and out_ready=0.
  - out_last=1 only on the count-th word of the burst.
- DRAIN: wait for the out_last handshake, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy=1 in ISSUE and DRAIN only. start is ignored while busy=1. start is accepted in the DONE cycle and handled as in IDLE on the next edge.
- Timing: start sampled at edge E0. acc_rd_en=1 in the cycle after E0. First out_valid=1 after E0+2 edges.
- Throughput: with out_ready held at 1, one word per cycle, no bubbles.
- Latency: a burst of n words completes with done at cycle n+3 after E0.
- Holding out_ready=0 stalls issue after at most 2 outstanding words. No data is lost or duplicated.

Test Plan:
- Basic burst: base=0x010, count=4, relu_en=0, acc words {3C00,4000,C000,0000}, out_ready=1 -> acc_rd_addr 010..013 on consecutive cycles; out_data 3C00,4000,C000,0000 on consecutive cycles; out_last on 0000; done exactly 1 cycle later.
- ReLU: same data with relu_en=1 -> output 3C00,4000,0000,0000. Also check that 8000 and FE00 inputs produce 0000.
- Wrap: base=1022, count=4 -> read addresses 1022,1023,0,1; 4 words out; out_last on the word from address 1.
- Backpressure: count=8 with out_ready toggling 1,0,0,1,... -> at most 2 reads outstanding beyond accepted words; all 8 words appear in order with no duplicates; out_data stable while stalled.
- Edge commands: count=0 -> done pulse 1 cycle after start, acc_rd_en never asserted. A start pulse while busy is ignored. A start in the done cycle launches the next burst.
- Reset mid-burst: assert reset after 3 of 8 words -> all outputs 0 immediately. A new burst after reset streams correctly with no stale FIFO data.
